// File: rtl/ahb_lite_master_if.sv
// Command/response handshake plus AHB-Lite bus signals of the single-transfer master.
// The master modport is the DUT view; the slave modport is the view of whatever drives it.
interface ahb_lite_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_error;
    logic [63:0] rsp_rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [63:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [63:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HREADY, HRESP, HRDATA,
        output cmd_ready, rsp_valid, rsp_error, rsp_rdata,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HREADY, HRESP, HRDATA,
        input  cmd_ready, rsp_valid, rsp_error, rsp_rdata,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite master issuing one non-pipelined 64-bit NONSEQ transfer per accepted command
// and reporting completion with a single-cycle response pulse.
module ahb_lite_master (
    input  logic              HCLK,
    input  logic              HRESET,
    ahb_lite_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t      state;
    logic        wr_lat;
    logic [63:0] wdata_lat;

    assign bus.HSIZE     = 3'b011;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = 4'h1;
    assign bus.HMASTLOCK = 1'b0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state         <= IDLE;
            wr_lat        <= 1'b0;
            wdata_lat     <= '0;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_error <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.HADDR     <= '0;
            bus.HTRANS    <= TRANS_IDLE;
            bus.HWRITE    <= 1'b0;
            bus.HWDATA    <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_error <= 1'b0;
            case (state)
                IDLE: begin
                    // cmd_ready is low for the first cycle out of reset, so gate acceptance on it
                    if (bus.cmd_ready && bus.cmd_valid && bus.cmd_addr[2:0] == 3'b000) begin
                        state         <= ADDR;
                        bus.cmd_ready <= 1'b0;
                        wr_lat        <= bus.cmd_write;
                        wdata_lat     <= bus.cmd_wdata;
                        bus.HADDR     <= bus.cmd_addr;
                        bus.HWRITE    <= bus.cmd_write;
                        bus.HTRANS    <= TRANS_NONSEQ;
                    end else begin
                        bus.cmd_ready <= 1'b1;
                        if (bus.cmd_ready && bus.cmd_valid) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_error <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (bus.HREADY) begin
                        state      <= DATA;
                        bus.HTRANS <= TRANS_IDLE;
                        if (wr_lat) begin
                            bus.HWDATA <= wdata_lat;
                        end
                    end
                end
                DATA: begin
                    if (bus.HRESP) begin
                        // ERROR seen with HREADY already high is closed out like a normal ERR exit
                        if (bus.HREADY) begin
                            state         <= IDLE;
                            bus.cmd_ready <= 1'b1;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_error <= 1'b1;
                        end else begin
                            state <= ERR;
                        end
                    end else if (bus.HREADY) begin
                        state         <= IDLE;
                        bus.cmd_ready <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        if (!wr_lat) begin
                            bus.rsp_rdata <= bus.HRDATA;
                        end
                    end
                end
                ERR: begin
                    if (bus.HREADY) begin
                        state         <= IDLE;
                        bus.cmd_ready <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_error <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomized bench for ahb_lite_master: a transaction-level plan drives the slave side and
// predicts bus phases, response timing, error flag and read data from the command outcomes.
module tb_ahb_lite_master;
    logic HCLK = 1'b0;
    logic HRESET;

    always #5 HCLK = ~HCLK;

    ahb_lite_master_if bus ();

    ahb_lite_master dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    // kind: 0 = OKAY, 1 = two-cycle ERROR, 2 = ERROR with HREADY high in first cycle
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [63:0] wd;
        int          aw;
        int          dw;
        int          kind;
        int          ew;
        int          gap;
        logic [63:0] rd;
    } txn_t;

    txn_t        tq[$];
    txn_t        t;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rsp_due = -1;
    bit          rsp_err_exp;
    logic [63:0] model_rdata;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input bit wr, input logic [31:0] addr, input logic [63:0] wd,
                                input int aw, input int dw, input int kind, input int ew,
                                input int gap, input logic [63:0] rd);
        txn_t r;
        r.wr = wr; r.addr = addr; r.wd = wd; r.aw = aw; r.dw = dw;
        r.kind = kind; r.ew = ew; r.gap = gap; r.rd = rd;
        return r;
    endfunction

    // Advance to the middle of the next cycle and check the response expected there.
    task automatic next_cycle();
        @(negedge HCLK);
        cyc++;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(cyc == rsp_due));
        if (cyc == rsp_due) begin
            chk("rsp_error", 64'(bus.rsp_error), 64'(rsp_err_exp));
            chk("rsp_rdata", bus.rsp_rdata, model_rdata);
            rsp_due = -1;
        end
    endtask

    task automatic drive_cmd(input txn_t c);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = c.wr;
        bus.cmd_addr  = c.addr;
        bus.cmd_wdata = c.wd;
    endtask

    // While a transfer runs, the next command is already held valid when it follows back-to-back.
    task automatic drive_follow(input int i);
        if (i + 1 < tq.size() && tq[i].gap == 0) drive_cmd(tq[i + 1]);
        else bus.cmd_valid = 1'b0;
    endtask

    task automatic data_checks(input txn_t c);
        chk("htrans_data", 64'(bus.HTRANS), 64'h0);
        chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'h0);
        if (c.wr) chk("hwdata", bus.HWDATA, c.wd);
    endtask

    task automatic run_txn(input int i);
        txn_t c;
        c = tq[i];
        next_cycle();
        chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'h1);
        chk("htrans_idle", 64'(bus.HTRANS), 64'h0);
        drive_cmd(c);
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        if (c.addr[2:0] != 3'b000) begin
            rsp_due     = cyc + 1;
            rsp_err_exp = 1'b1;
        end else begin
            for (int k = 0; k <= c.aw; k++) begin
                next_cycle();
                chk("htrans_nonseq", 64'(bus.HTRANS), 64'h2);
                chk("haddr", 64'(bus.HADDR), 64'(c.addr));
                chk("hwrite", 64'(bus.HWRITE), 64'(c.wr));
                chk("cmd_ready_addr", 64'(bus.cmd_ready), 64'h0);
                drive_follow(i);
                bus.HREADY = (k == c.aw);
                bus.HRESP  = 1'b0;
                bus.HRDATA = {$urandom, $urandom};
            end
            for (int k = 0; k < c.dw; k++) begin
                next_cycle();
                data_checks(c);
                drive_follow(i);
                bus.HREADY = 1'b0;
                bus.HRESP  = 1'b0;
                bus.HRDATA = {$urandom, $urandom};
            end
            next_cycle();
            data_checks(c);
            drive_follow(i);
            if (c.kind == 0) begin
                bus.HREADY  = 1'b1;
                bus.HRESP   = 1'b0;
                bus.HRDATA  = c.rd;
                rsp_err_exp = 1'b0;
                if (!c.wr) model_rdata = c.rd;
            end else if (c.kind == 1) begin
                bus.HREADY = 1'b0;
                bus.HRESP  = 1'b1;
                bus.HRDATA = {$urandom, $urandom};
                for (int k = 0; k <= c.ew; k++) begin
                    next_cycle();
                    chk("htrans_err", 64'(bus.HTRANS), 64'h0);
                    chk("cmd_ready_err", 64'(bus.cmd_ready), 64'h0);
                    drive_follow(i);
                    bus.HREADY = (k == c.ew);
                    bus.HRESP  = 1'b1;
                end
                rsp_err_exp = 1'b1;
            end else begin
                bus.HREADY  = 1'b1;
                bus.HRESP   = 1'b1;
                bus.HRDATA  = {$urandom, $urandom};
                rsp_err_exp = 1'b1;
            end
            rsp_due = cyc + 1;
        end
        for (int g = 0; g < c.gap; g++) begin
            next_cycle();
            chk("cmd_ready_gap", 64'(bus.cmd_ready), 64'h1);
            chk("htrans_gap", 64'(bus.HTRANS), 64'h0);
            bus.cmd_valid = 1'b0;
            bus.HREADY    = 1'b1;
            bus.HRESP     = 1'b0;
        end
    endtask

    task automatic reset_mid_op();
        next_cycle();
        chk("cmd_ready_pre_rst", 64'(bus.cmd_ready), 64'h1);
        drive_cmd(mk(1'b0, 32'h0000_0300, 64'h0, 0, 0, 0, 0, 1, 64'h0));
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        next_cycle();
        chk("htrans_rst_addr", 64'(bus.HTRANS), 64'h2);
        bus.cmd_valid = 1'b0;
        next_cycle();
        bus.HREADY = 1'b0;
        next_cycle();
        chk("htrans_rst_data", 64'(bus.HTRANS), 64'h0);
        HRESET = 1'b1;
        next_cycle();
        chk("htrans_in_rst", 64'(bus.HTRANS), 64'h0);
        chk("cmd_ready_in_rst", 64'(bus.cmd_ready), 64'h0);
        chk("haddr_in_rst", 64'(bus.HADDR), 64'h0);
        chk("rsp_rdata_in_rst", bus.rsp_rdata, 64'h0);
        HRESET      = 1'b0;
        bus.HREADY  = 1'b1;
        model_rdata = '0;
        next_cycle();
        chk("cmd_ready_after_rst", 64'(bus.cmd_ready), 64'h1);
        repeat (3) next_cycle();
    endtask

    initial begin
        HRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
        bus.HRDATA    = '0;
        model_rdata   = '0;

        repeat (3) next_cycle();
        chk("htrans_rst", 64'(bus.HTRANS), 64'h0);
        chk("haddr_rst", 64'(bus.HADDR), 64'h0);
        chk("hwrite_rst", 64'(bus.HWRITE), 64'h0);
        chk("hwdata_rst", bus.HWDATA, 64'h0);
        chk("rsp_error_rst", 64'(bus.rsp_error), 64'h0);
        chk("rsp_rdata_rst", bus.rsp_rdata, 64'h0);
        chk("cmd_ready_rst", 64'(bus.cmd_ready), 64'h0);
        chk("hsize_rst", 64'(bus.HSIZE), 64'h3);
        chk("hburst_rst", 64'(bus.HBURST), 64'h0);
        chk("hprot_rst", 64'(bus.HPROT), 64'h1);
        chk("hmastlock_rst", 64'(bus.HMASTLOCK), 64'h0);
        HRESET = 1'b0;

        tq.push_back(mk(1'b1, 32'h0000_0100, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 1, 64'h0));
        tq.push_back(mk(1'b0, 32'h0000_0200, 64'h0, 0, 3, 0, 0, 1, 64'hABCD_EF12_3456_7890));
        tq.push_back(mk(1'b0, 32'h0000_2000, 64'h0, 0, 0, 1, 0, 1, 64'h0));
        tq.push_back(mk(1'b1, 32'h0000_0104, 64'h5555_AAAA_5555_AAAA, 0, 0, 0, 0, 1, 64'h0));
        tq.push_back(mk(1'b1, 32'h0000_0400, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0, 0, 64'h0));
        tq.push_back(mk(1'b0, 32'h0000_0408, 64'h0, 1, 1, 0, 0, 0, 64'h1122_3344_5566_7788));
        tq.push_back(mk(1'b0, 32'h0000_0503, 64'h0, 0, 0, 0, 0, 0, 64'h0));
        tq.push_back(mk(1'b0, 32'h0000_0410, 64'h0, 0, 0, 2, 0, 1, 64'h0));
        for (int i = 0; i < 40; i++) begin
            t.wr   = 1'($urandom_range(0, 1));
            t.addr = $urandom & 32'hFFFF_FFF8;
            if ($urandom_range(0, 5) == 0) t.addr[2:0] = 3'($urandom_range(1, 7));
            t.wd   = {$urandom, $urandom};
            t.aw   = $urandom_range(0, 2);
            t.dw   = $urandom_range(0, 3);
            t.kind = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 2);
            t.ew   = $urandom_range(0, 2);
            t.gap  = $urandom_range(0, 2);
            t.rd   = {$urandom, $urandom};
            tq.push_back(t);
        end
        tq[tq.size() - 1].gap = 1;

        for (int i = 0; i < tq.size(); i++) run_txn(i);
        reset_mid_op();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 The block SHALL have port HCLK, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port HRESET, input, 1 bit: synchronous active-high reset, sampled on the HCLK rising edge.
REQ-004 The block SHALL have command ports: cmd_valid in 1, cmd_ready out 1, cmd_write in 1 (1=write), cmd_addr in 32, cmd_wdata in 64.
REQ-005 The block SHALL have response ports: rsp_valid out 1 (one-cycle pulse), rsp_error out 1, rsp_rdata out 64.
REQ-006 The block SHALL have AHB-Lite outputs: HADDR 32, HTRANS 2, HWRITE 1, HSIZE 3, HBURST 3, HPROT 4, HMASTLOCK 1, HWDATA 64.
REQ-007 The block SHALL have AHB-Lite inputs: HREADY 1, HRESP 1 (1=ERROR), HRDATA 64.

Function
REQ-008 The block SHALL issue single, non-pipelined 64-bit transfers with constant outputs HSIZE=3'b011, HBURST=3'b000, HPROT=4'h1 and HMASTLOCK=0.
REQ-009 The FSM SHALL have exactly the states IDLE, ADDR, DATA, ERR and SHALL drive cmd_ready=1 only in IDLE.
REQ-010 In IDLE with cmd_valid=1 and cmd_addr[2:0]=0, the block SHALL latch cmd_write, cmd_addr and cmd_wdata and move to ADDR.
REQ-011 In IDLE with cmd_valid=1 and cmd_addr[2:0]!=0, the block SHALL perform no bus transfer, pulse rsp_valid=1 with rsp_error=1 on the next cycle, and remain in IDLE.
REQ-012 In ADDR, the block SHALL drive HTRANS=2'b10 (NONSEQ), HADDR=latched address and HWRITE=latched write flag.
REQ-013 In ADDR with HREADY=1, the block SHALL move to DATA; with HREADY=0 it SHALL hold ADDR with all address-phase outputs unchanged.
REQ-014 In every state other than ADDR, the block SHALL drive HTRANS=2'b00 (IDLE).
REQ-015 In DATA, the block SHALL drive HWDATA=latched write data for writes and SHALL hold HWDATA stable through all wait states.
REQ-016 In DATA with HREADY=0 and HRESP=0, the block SHALL stay in DATA, with no limit on the number of wait states.
REQ-017 In DATA with HREADY=1 and HRESP=0, the block SHALL return to IDLE and, on the next cycle, pulse rsp_valid=1 with rsp_error=0; for a read it SHALL present rsp_rdata=HRDATA as sampled in that cycle.
REQ-018 In DATA with HRESP=1 and HREADY=0 (first ERROR cycle), the block SHALL move to ERR.
REQ-019 In ERR with HREADY=1, the block SHALL return to IDLE and, on the next cycle, pulse rsp_valid=1 with rsp_error=1; with HREADY=0 it SHALL stay in ERR.
REQ-020 In DATA with HRESP=1 and HREADY=1 (protocol violation), the block SHALL treat the transfer as an error completion, identical to the ERR exit in REQ-019.
REQ-021 rsp_valid SHALL be high for exactly one cycle per accepted command.
REQ-022 rsp_rdata SHALL hold its last value until the next successful read and SHALL be unchanged by writes and errors.
REQ-023 A new command SHALL be acceptable in the same cycle that rsp_valid is high.
REQ-024 Minimum latency SHALL be 3 cycles from acceptance to rsp_valid: accept at T, address phase T+1, data phase T+2, rsp_valid T+3.

Reset
REQ-025 While HRESET=1, the FSM SHALL go to IDLE, and the block SHALL drive HTRANS=2'b00, HADDR=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_error=0, rsp_rdata=0 and cmd_ready=0.
REQ-026 After reset, cmd_ready SHALL be 1 from the first cycle after HRESET deasserts.
REQ-027 Reset asserted mid-transfer (ADDR, DATA or ERR) SHALL abandon the transfer with no rsp_valid pulse.
REQ-028 The constant outputs of REQ-008 SHALL keep their values during reset.

Verification
REQ-029 Zero-wait write: cmd addr=0x00000100, wdata=0x0123456789ABCDEF, HREADY=1 always -> HTRANS=NONSEQ at T+1, HWDATA=0x0123456789ABCDEF at T+2, rsp_valid=1 and rsp_error=0 at T+3.
REQ-030 Wait-state read: addr=0x00000200, HREADY=0 for 3 data cycles, then HREADY=1 with HRDATA=0xABCDEF1234567890 -> rsp_valid at T+6, rsp_rdata=0xABCDEF1234567890.
REQ-031 Two-cycle ERROR: read to 0x00002000, slave returns HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> state ERR, rsp_valid=1 and rsp_error=1 one cycle later, rsp_rdata unchanged.
REQ-032 Misaligned address: cmd addr=0x00000104 -> HTRANS stays 2'b00, rsp_valid=1 and rsp_error=1 at T+1.
REQ-033 Reset mid-operation: HRESET=1 during a DATA wait state -> next cycle HTRANS=00, rsp_valid=0, cmd_ready=0; cmd_ready=1 the cycle after HRESET drops.
REQ-034 Back-to-back: a second cmd_valid held high through the first transfer -> second command accepted in the rsp_valid cycle of the first, both responses correct.
